// File: rtl/cache_types_pkg.sv
// Shared types for the victim cache bank: FSM state encoding and small helpers.
// Entry widths depend on module parameters, so the entry struct lives in the bank itself.
// FLUSH_* states exist only when VICTIM_FLUSH_EN is defined.
package cache_types;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WB         = 2'd1
`ifdef VICTIM_FLUSH_EN
    ,
    ST_FLUSH_SCAN = 2'd2,
    ST_FLUSH_WB   = 2'd3
`endif
  } victim_state_t;

  // A line must go back to memory only if it holds data and was modified.
  function automatic logic needs_writeback(input logic valid, input logic dirty);
    return valid & dirty;
  endfunction

endpackage

// File: rtl/victim_age_lru.sv
// Age-based LRU for a fully associative bank: age 0 is youngest, NUM_WAYS-1 is oldest.
// Latency: touch takes effect at the next edge; oldest_way is combinational from the age registers.
// Backpressure: none, a touch is applied unconditionally whenever it is presented.
module victim_age_lru
  import cache_types::*;
#(
  parameter  int NUM_WAYS  = 4,
  localparam int AGE_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 touch,
  input  logic [AGE_WIDTH-1:0] touch_way,
  output logic [AGE_WIDTH-1:0] oldest_way
);

  logic [AGE_WIDTH-1:0] age [NUM_WAYS];

  // Touched way becomes youngest; everything younger than it ages by one, keeping a permutation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        age[i] <= AGE_WIDTH'(i);
      end
    end else if (touch) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (AGE_WIDTH'(i) == touch_way) begin
          age[i] <= '0;
        end else if (age[i] < age[touch_way]) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  // Exactly one way carries the maximum age; encode its index.
  always_comb begin
    oldest_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (age[i] == AGE_WIDTH'(NUM_WAYS - 1)) begin
        oldest_way = AGE_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/victim_cache_bank.sv
// Fully associative victim cache bank between L1 and pmem; probe/insert with swap on hit, dirty writeback.
// Latency: hit data combinational; insert lands next edge; a dirty eviction holds the bank 1 + pmem latency cycles.
// Backpressure: req_ready drops while a writeback (or flush, with VICTIM_FLUSH_EN) is in flight; inputs ignored then.
module victim_cache_bank
  import cache_types::*;
#(
  parameter  int NUM_WAYS   = 4,
  parameter  int TAG_WIDTH  = 12,
  parameter  int LINE_WIDTH = 128,
  localparam int AGE_WIDTH  = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  hit,
  output logic [LINE_WIDTH-1:0] hit_line,
  output logic                  hit_dirty,
  input  logic                  ins_valid,
  input  logic [TAG_WIDTH-1:0]  ins_tag,
  input  logic [LINE_WIDTH-1:0] ins_line,
  input  logic                  ins_dirty,
  output logic                  pmem_write,
  output logic [TAG_WIDTH-1:0]  pmem_tag,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic                  flush,
  output logic                  flush_done
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] line;
    logic                  valid;
    logic                  dirty;
  } victim_entry_t;

  victim_entry_t         ways [NUM_WAYS];
  victim_state_t         state;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic [LINE_WIDTH-1:0] wb_line;

  logic [NUM_WAYS-1:0]   match_vec;
  logic [NUM_WAYS-1:0]   ins_match_vec;
  logic [AGE_WIDTH-1:0]  hit_way;
  logic [LINE_WIDTH-1:0] line_or;
  logic                  dirty_or;
  logic                  has_free;
  logic [AGE_WIDTH-1:0]  free_way;
  logic [AGE_WIDTH-1:0]  oldest_way;
  logic [AGE_WIDTH-1:0]  target_way;
  logic                  probe_acc;
  logic                  ins_acc;
  logic                  evict;

`ifdef VICTIM_FLUSH_EN
  localparam logic [AGE_WIDTH-1:0] LAST_WAY = AGE_WIDTH'(NUM_WAYS - 1);
  logic [AGE_WIDTH-1:0] scan_idx;
  logic                 flush_clr;

  assign req_ready = (state == ST_IDLE) & ~flush;
  assign flush_clr = (state == ST_FLUSH_SCAN) &
                     needs_writeback(ways[scan_idx].valid, ways[scan_idx].dirty);
`else
  logic unused_flush;

  assign req_ready    = (state == ST_IDLE);
  assign flush_done   = 1'b0;
  assign unused_flush = flush;
`endif

  assign probe_acc = req_valid & req_ready;
  assign ins_acc   = ins_valid & req_ready;

  // Parallel tag compare; L1 exclusivity means at most one way matches, so data can be OR-reduced.
  always_comb begin
    match_vec     = '0;
    ins_match_vec = '0;
    hit_way       = '0;
    line_or       = '0;
    dirty_or      = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      match_vec[i]     = ways[i].valid && (ways[i].tag == req_tag);
      ins_match_vec[i] = ways[i].valid && (ways[i].tag == ins_tag);
      if (match_vec[i]) begin
        hit_way  = AGE_WIDTH'(i);
        line_or  = line_or | ways[i].line;
        dirty_or = dirty_or | ways[i].dirty;
      end
    end
  end

  assign hit       = probe_acc & (|match_vec);
  assign hit_line  = hit ? line_or : '0;
  assign hit_dirty = hit & dirty_or;

  // Insert target: swap into the hit way, else lowest free way, else the LRU way.
  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!ways[i].valid) begin
        has_free = 1'b1;
        free_way = AGE_WIDTH'(i);
      end
    end
    if (hit) begin
      target_way = hit_way;
    end else if (has_free) begin
      target_way = free_way;
    end else begin
      target_way = oldest_way;
    end
  end

  // A swapped-out hit line goes to L1, so only a non-hit dirty victim needs memory.
  assign evict = ins_acc & ~hit &
                 needs_writeback(ways[target_way].valid, ways[target_way].dirty);

  victim_age_lru #(
    .NUM_WAYS (NUM_WAYS)
  ) u_age_lru (
    .clk        (clk),
    .reset_n    (reset_n),
    .touch      (ins_acc),
    .touch_way  (target_way),
    .oldest_way (oldest_way)
  );

  // Way storage: write inserted victims, drop lines handed to L1, clear dirty once flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        ways[i] <= '0;
      end
    end else begin
      if (ins_acc) begin
        ways[target_way] <= '{tag: ins_tag, line: ins_line, valid: 1'b1, dirty: ins_dirty};
      end else if (hit) begin
        ways[hit_way].valid <= 1'b0;
      end
`ifdef VICTIM_FLUSH_EN
      if (flush_clr) begin
        ways[scan_idx].dirty <= 1'b0;
      end
`endif
    end
  end

  // Control FSM: owns the writeback buffer and the registered pmem/flush outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wb_tag     <= '0;
      wb_line    <= '0;
      pmem_write <= 1'b0;
`ifdef VICTIM_FLUSH_EN
      scan_idx   <= '0;
      flush_done <= 1'b0;
`endif
    end else begin
`ifdef VICTIM_FLUSH_EN
      flush_done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (evict) begin
            wb_tag     <= ways[target_way].tag;
            wb_line    <= ways[target_way].line;
            pmem_write <= 1'b1;
            state      <= ST_WB;
          end
`ifdef VICTIM_FLUSH_EN
          else if (flush) begin
            scan_idx <= '0;
            state    <= ST_FLUSH_SCAN;
          end
`endif
        end
        ST_WB: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            state      <= ST_IDLE;
          end
        end
`ifdef VICTIM_FLUSH_EN
        ST_FLUSH_SCAN: begin
          if (flush_clr) begin
            wb_tag     <= ways[scan_idx].tag;
            wb_line    <= ways[scan_idx].line;
            pmem_write <= 1'b1;
            state      <= ST_FLUSH_WB;
          end else if (scan_idx == LAST_WAY) begin
            flush_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_FLUSH_WB: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            if (scan_idx == LAST_WAY) begin
              flush_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              scan_idx <= scan_idx + 1'b1;
              state    <= ST_FLUSH_SCAN;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pmem_tag   = wb_tag;
  assign pmem_wdata = wb_line;

  // L1 keeps itself exclusive with this bank: a probe matches one way at most, and an
  // inserted tag may already live only in the way it is swapping with.
  a_onehot_match: assert property (@(posedge clk) disable iff (!reset_n)
    req_valid |-> $onehot0(match_vec));
  a_insert_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    ins_acc |-> ((ins_match_vec & ~(hit ? match_vec : '0)) == '0));

endmodule
